single_port_syn_ram: RTL and testbench
======================================

SINGLE_PORT_SYN_RAM -- requirements
Module: single_port_syn_ram

Interface
REQ-001 The module SHALL have parameter data_width, default 32, which sets the data word width in bits.
REQ-002 The module SHALL have parameter addr_width, default 10, which sets the address width; depth SHALL be 2**addr_width words (1024 by default).
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rstn SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port en SHALL be an input, 1 bit wide: access enable; no access SHALL occur while it is 0.
REQ-006 Port wr_rdn SHALL be an input, 1 bit wide: access type, 1 = write, 0 = read.
REQ-007 Port addr SHALL be an input, addr_width bits wide: word address.
REQ-008 Port data_wr SHALL be an input, data_width bits wide: write data.
REQ-009 Port data_rd SHALL be an output, data_width bits wide, driven by a register: read data.

Function
REQ-010 On a rising clk edge with en=1 and wr_rdn=1, the module SHALL store data_wr into mem[addr].
- Write data SHALL be readable from the next cycle onward.
REQ-011 On a rising clk edge with en=1 and wr_rdn=0, the module SHALL load data_rd with mem[addr].
- Read latency SHALL be 1 cycle: the value is valid immediately after the edge that sampled en=1.
REQ-012 data_rd SHALL hold its last value in every cycle with no read, including write cycles (no-change mode), cycles with en=0, and cycles after en deasserts.
REQ-013 While en=0, the module SHALL ignore wr_rdn, addr and data_wr, and memory SHALL be unchanged.
REQ-014 The full address range 0 to 2**addr_width-1 SHALL be accessible, with no wrap-around or aliasing; address 0 and address 0x3FF are ordinary locations.
REQ-015 Back-to-back accesses on consecutive cycles SHALL be supported with no wait states.
- A read that immediately follows a write to the same address SHALL return the new data.
REQ-016 Memory contents SHALL be undefined after power-up; a read of a never-written location returns unspecified data.
REQ-017 The module SHALL have no handshake, no error output and no busy output.

Reset
REQ-018 While rstn=0, data_rd SHALL be forced to 0 asynchronously.
REQ-019 Reset SHALL NOT clear or modify memory contents.
REQ-020 An access whose enabling edge occurs while rstn=0 SHALL be ignored.
REQ-021 After rstn deasserts, the first rising clk edge with en=1 SHALL perform a normal access.
REQ-022 A reset asserted mid-sequence SHALL clear only data_rd; data written before the reset SHALL remain readable afterward.

Structure
REQ-023 The default width constants (DATA_WIDTH=32, ADDR_WIDTH=10) SHALL reside in a shared package, single_port_syn_ram_pkg, and the module parameters SHALL default from it.
REQ-024 The storage array SHALL be a separate sub-module, spram_array: synchronous write and registered read, no reset, inferable as block RAM.
- The top level SHALL contain the access decode and the resettable data_rd register.

Verification
REQ-025 Reset: hold rstn=0 with en=0 -> data_rd=0x00000000; release rstn -> data_rd stays 0 while en=0.
REQ-026 Write then read:
- Write 0xDEADBEEF to addr 0x155 (en=1, wr_rdn=1 for one edge).
- Read addr 0x155 (en=1, wr_rdn=0 for one edge) -> data_rd=0xDEADBEEF right after that edge.
- data_rd holds that value after en drops.
REQ-027 Boundaries: write 0x12345678 to addr 0x000 and 0x9ABCDEF0 to addr 0x3FF -> reads return each value unchanged; neither write corrupts the other location.
REQ-028 Enable gating and hold:
- With en=0, wr_rdn=1, addr 0x155, data_wr=0xFFFFFFFF for 3 edges -> a later read of 0x155 returns 0xDEADBEEF.
- A write cycle to 0x200 -> data_rd keeps its previous value.
REQ-029 Reset mid-operation: after REQ-026, pulse rstn low between edges -> data_rd=0 immediately; a subsequent read of 0x155 returns 0xDEADBEEF.
REQ-030 Random: 5 iterations of a random write to a random address x, each followed by a read of x -> each read returns the data just written, with 1-cycle latency.

Source files
------------

// File: rtl/single_port_syn_ram_pkg.sv
// Shared constants and access-decode helper for single_port_syn_ram.
//   DATA_WIDTH   : default data word width (bits)
//   ADDR_WIDTH   : default address width (depth = 2**ADDR_WIDTH words)
//   access_e     : decoded access type for one clock edge
//   decode_access: maps en/wr_rdn onto access_e
package single_port_syn_ram_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'b00,
    ACC_READ  = 2'b01,
    ACC_WRITE = 2'b10
  } access_e;

  function automatic access_e decode_access(input logic en, input logic wr_rdn);
    if (!en) begin
      return ACC_NONE;
    end
    return wr_rdn ? ACC_WRITE : ACC_READ;
  endfunction

endpackage

// File: rtl/spram_array.sv
// Storage array for single_port_syn_ram: synchronous write, registered read,
// no reset, so it maps onto a block RAM.
//   clk     : clock, rising edge
//   wr_en   : write mem[addr] <= wr_data on this edge
//   rd_en   : load rd_data from mem[addr] on this edge, otherwise hold
//   addr    : word address
//   wr_data : write data
//   rd_data : registered read data
module spram_array #(
  parameter int data_width = 32,
  parameter int addr_width = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wr_data,
  output logic [data_width-1:0] rd_data
);

  localparam int DEPTH = 2 ** addr_width;

  logic [data_width-1:0] mem [DEPTH];
  logic [data_width-1:0] rd_data_q;
  logic [data_width-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/single_port_syn_ram.sv
// Single-port synchronous RAM, one-cycle read latency, no-change read port.
//   clk     : clock, rising edge
//   rstn    : asynchronous active-low reset; clears data_rd only, never memory
//   en      : access enable
//   wr_rdn  : 1 = write, 0 = read
//   addr    : word address
//   data_wr : write data
//   data_rd : read data, holds between reads, 0 from reset until first read
module single_port_syn_ram
  import single_port_syn_ram_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int addr_width = ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  wr_rdn,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] data_wr,
  output logic [data_width-1:0] data_rd
);

  access_e               acc;
  logic                  wr_en;
  logic                  rd_en;
  logic [data_width-1:0] arr_rd;

  // Masks the (unresettable) array output register until the first read
  // after reset, which makes data_rd behave as a resettable register.
  logic rd_zero_q;
  logic rd_zero_d;

  // Accesses on an edge that lands inside reset are dropped.
  always_comb begin
    acc = ACC_NONE;
    if (rstn) begin
      acc = decode_access(en, wr_rdn);
    end
  end

  assign wr_en = (acc == ACC_WRITE);
  assign rd_en = (acc == ACC_READ);

  spram_array #(
    .data_width(data_width),
    .addr_width(addr_width)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .addr   (addr),
    .wr_data(data_wr),
    .rd_data(arr_rd)
  );

  always_comb begin
    rd_zero_d = rd_zero_q;
    if (rd_en) begin
      rd_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_zero_q <= 1'b1;
    end else begin
      rd_zero_q <= rd_zero_d;
    end
  end

  assign data_rd = rd_zero_q ? '0 : arr_rd;

endmodule

// File: tb/tb_single_port_syn_ram.sv
module tb_single_port_syn_ram;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        wr_rdn = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] data_wr = '0;
  logic [31:0] data_rd;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: plain word array plus a "written" flag per address.
  logic [31:0] model_mem [1024];
  bit          model_written [1024];
  logic [31:0] exp_rd = '0;
  bit          exp_known = 1'b1;

  single_port_syn_ram dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .wr_rdn (wr_rdn),
    .addr   (addr),
    .data_wr(data_wr),
    .data_rd(data_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_rd    <= '0;
      exp_known <= 1'b1;
    end else if (en) begin
      if (wr_rdn) begin
        model_mem[addr]     <= data_wr;
        model_written[addr] <= 1'b1;
      end else if (model_written[addr]) begin
        exp_rd    <= model_mem[addr];
        exp_known <= 1'b1;
      end else begin
        exp_known <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (exp_known) begin
      chk("model_compare", data_rd, exp_rd);
    end
  end

  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    addr = a; data_wr = d; wr_rdn = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a);
    addr = a; wr_rdn = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0]  ra;
    logic [31:0] rd;

    // Reset with en low.
    idle(3);
    chk("reset_zero", data_rd, 32'h0);
    rstn = 1'b1;
    idle(2);
    chk("post_reset_idle", data_rd, 32'h0);

    // Write then read.
    do_write(10'h155, 32'hDEADBEEF);
    chk("write_no_change", data_rd, 32'h0);
    do_read(10'h155);
    chk("read_155", data_rd, 32'hDEADBEEF);
    idle(2);
    chk("hold_after_en_drop", data_rd, 32'hDEADBEEF);

    // Boundaries.
    do_write(10'h000, 32'h12345678);
    do_write(10'h3FF, 32'h9ABCDEF0);
    do_read(10'h000);
    chk("read_000", data_rd, 32'h12345678);
    do_read(10'h3FF);
    chk("read_3ff", data_rd, 32'h9ABCDEF0);
    do_read(10'h000);
    chk("reread_000", data_rd, 32'h12345678);

    // Enable gating: inputs toggle while en is low.
    addr = 10'h155; data_wr = 32'hFFFFFFFF; wr_rdn = 1'b1; en = 1'b0;
    idle(3);
    chk("gated_hold", data_rd, 32'h12345678);
    do_read(10'h155);
    chk("gated_no_write", data_rd, 32'hDEADBEEF);
    do_write(10'h200, 32'h0BADF00D);
    chk("write_cycle_hold", data_rd, 32'hDEADBEEF);
    do_read(10'h200);
    chk("read_200", data_rd, 32'h0BADF00D);

    // Mid-operation reset, with a write attempted on an edge inside reset.
    do_read(10'h155);
    chk("pre_reset_read", data_rd, 32'hDEADBEEF);
    #1 rstn = 1'b0;
    #1 chk("async_reset_zero", data_rd, 32'h0);
    addr = 10'h155; data_wr = 32'h00000000; wr_rdn = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    chk("reset_held_zero", data_rd, 32'h0);
    rstn = 1'b1;
    idle(1);
    chk("after_release_zero", data_rd, 32'h0);
    do_read(10'h155);
    chk("read_after_reset", data_rd, 32'hDEADBEEF);

    // Random write-then-read pairs.
    for (int i = 0; i < 5; i++) begin
      ra = 10'($urandom_range(0, 1023));
      rd = $urandom;
      do_write(ra, rd);
      do_read(ra);
      chk("random_wr_rd", data_rd, rd);
    end

    // Back-to-back random traffic, checked by the model compare process.
    for (int i = 0; i < 300; i++) begin
      addr    = 10'($urandom_range(0, 1023));
      data_wr = $urandom;
      wr_rdn  = 1'($urandom_range(0, 1));
      en      = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    en = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
